// File: rtl/serial_pattern_seq.sv
// Serialises a captured pattern LSB-first for 1 + repeat_cnt passes, then pulses done.
// Optional SEQ_PARITY_EN appends an even-parity bit after every pass.
module serial_pattern_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef SEQ_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_pat, w_pat_nx;
    logic [CNT_W-1:0] r_rep, w_rep_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx, w_idx_inc;
    logic             r_d_out, r_d_valid, r_busy, r_done, r_ready;
    logic             w_d_out_nx, w_d_valid_nx, w_busy_nx, w_done_nx, w_ready_nx;
    logic             w_pass_end;

    assign w_idx_inc = r_idx + IDX_W'(1);

    // Outputs are computed for the next state and registered, so they are
    // valid in the same cycle the state they describe is current.
    always_comb begin
        w_state_nx   = r_state;
        w_pat_nx     = r_pat;
        w_rep_nx     = r_rep;
        w_idx_nx     = r_idx;
        w_d_out_nx   = 1'b0;
        w_d_valid_nx = 1'b0;
        w_busy_nx    = 1'b0;
        w_done_nx    = 1'b0;
        w_ready_nx   = 1'b0;
        w_pass_end   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pat_nx     = pattern;
                    w_rep_nx     = repeat_cnt;
                    w_idx_nx     = '0;
                    w_state_nx   = S_SHIFT;
                    w_d_out_nx   = pattern[0];
                    w_d_valid_nx = 1'b1;
                    w_busy_nx    = 1'b1;
                end else begin
                    w_ready_nx   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_ready_nx = 1'b1;
                end else if (r_idx == LAST_IDX) begin
`ifdef SEQ_PARITY_EN
                    w_state_nx   = S_PARITY;
                    w_d_out_nx   = ^r_pat;
                    w_d_valid_nx = 1'b1;
                    w_busy_nx    = 1'b1;
`else
                    w_pass_end   = 1'b1;
`endif
                end else begin
                    w_idx_nx     = w_idx_inc;
                    w_d_out_nx   = r_pat[w_idx_inc];
                    w_d_valid_nx = 1'b1;
                    w_busy_nx    = 1'b1;
                end
            end
`ifdef SEQ_PARITY_EN
            S_PARITY: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_ready_nx = 1'b1;
                end else begin
                    w_pass_end = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_ready_nx = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_ready_nx = 1'b1;
            end
        endcase

        // End of a pass: restart at bit 0 while repeats remain, else finish.
        if (w_pass_end) begin
            if (r_rep != '0) begin
                w_rep_nx     = r_rep - CNT_W'(1);
                w_idx_nx     = '0;
                w_state_nx   = S_SHIFT;
                w_d_out_nx   = r_pat[0];
                w_d_valid_nx = 1'b1;
                w_busy_nx    = 1'b1;
            end else begin
                w_state_nx   = S_DONE;
                w_done_nx    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_rep     <= '0;
            r_idx     <= '0;
            r_d_out   <= 1'b0;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_pat     <= w_pat_nx;
            r_rep     <= w_rep_nx;
            r_idx     <= w_idx_nx;
            r_d_out   <= w_d_out_nx;
            r_d_valid <= w_d_valid_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_ready   <= w_ready_nx;
        end
    end

    assign d_out   = r_d_out;
    assign d_valid = r_d_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ready   = r_ready;

endmodule

// File: tb/tb_serial_pattern_seq.sv
// Table-driven bench for serial_pattern_seq; expected bits queued at start, popped on d_valid.
module tb_serial_pattern_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
`ifdef SEQ_PARITY_EN
    localparam int P = W + 1;
`else
    localparam int P = W;
`endif

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic          ready, d_out, d_valid, busy, done;
    logic [W-1:0]  pattern;
    logic [CW-1:0] repeat_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    serial_pattern_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .abort      (abort),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [W-1:0]  pat;
        logic [CW-1:0] rep;
        int            abort_at;   // cycle offset from start; 0 = none
        int            reset_at;
        int            glitch_at;  // start pulse with all-ones pattern
        int            gap;        // idle cycles before start
        bit            abort_with_start;
        bit            poke_done;  // start+abort during the done cycle
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_seq(input vec_t v);
        int  total, last, end_c, k;
        bit  normal, exp_valid, exp_done, b;
        repeat (v.gap) @(negedge clk);
        chk("ready_before_start", 32'(ready), 32'd1);
        total  = (int'(v.rep) + 1) * P;
        normal = (v.abort_at == 0) && (v.reset_at == 0);
        last   = normal ? total : ((v.abort_at != 0) ? v.abort_at : v.reset_at);
        end_c  = normal ? total + 2 : last + 1;
        k = 0;
        for (int p = 0; p <= int'(v.rep); p++) begin
            for (int i = 0; i < P; i++) begin
                if (k < last) exp_q.push_back((i < W) ? v.pat[i] : ^v.pat);
                k++;
            end
        end
        start      = 1'b1;
        pattern    = v.pat;
        repeat_cnt = v.rep;
        abort      = v.abort_with_start;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            exp_valid = (c <= last);
            exp_done  = normal && (c == total + 1);
            chk("d_valid", 32'(d_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(exp_valid));
            chk("done", 32'(done), 32'(exp_done));
            chk("ready", 32'(ready), 32'(!exp_valid && !exp_done));
            if (d_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_bit: got d_valid=1 expected no bit at t=%0t", $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("d_out", 32'(d_out), 32'(b));
                end
            end else begin
                chk("d_out_idle", 32'(d_out), 32'd0);
            end
            start      = 1'b0;
            abort      = 1'b0;
            reset      = 1'b0;
            pattern    = ~v.pat;
            repeat_cnt = ~v.rep;
            if (c == v.glitch_at) begin
                start   = 1'b1;
                pattern = '1;
            end
            if (c == v.abort_at) abort = 1'b1;
            if (c == v.reset_at) reset = 1'b1;
            if (v.poke_done && normal && c == total + 1) begin
                start = 1'b1;
                abort = 1'b1;
            end
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{8'hA5, 4'd0,  0,     0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{8'h0F, 4'd2,  0,     0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{8'h5A, 4'd0,  3,     0, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{8'hC3, 4'd0,  0,     0, 0, 0, 1'b0, 1'b0};
        tbl[4]  = '{8'h3C, 4'd1,  0,     4, 0, 0, 1'b0, 1'b0};
        tbl[5]  = '{8'h96, 4'd0,  0,     0, 0, 1, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 4'd0,  0,     0, 3, 0, 1'b0, 1'b0};
        tbl[7]  = '{8'h07, 4'd1,  0,     0, 0, 0, 1'b1, 1'b0};
        tbl[8]  = '{8'hE1, 4'd15, 0,     0, 0, 0, 1'b0, 1'b0};
        tbl[9]  = '{8'h81, 4'd1,  P,     0, 0, 0, 1'b0, 1'b0};
        tbl[10] = '{8'h33, 4'd0,  0,     0, 0, 1, 1'b0, 1'b1};
        tbl[11] = '{8'h01, 4'd0,  P,     0, 0, 0, 1'b0, 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);

        // Reset must beat a simultaneous start.
        start = 1'b1;
        pattern = 8'hFF;
        @(negedge clk);
        chk("rst_over_start_valid", 32'(d_valid), 32'd0);
        chk("rst_over_start_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        start = 1'b0;

        // Abort while idle is a no-op.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", 32'(ready), 32'd1);
        chk("idle_abort_valid", 32'(d_valid), 32'd0);

        for (int t = 0; t < 12; t++) run_seq(tbl[t]);

        repeat (2) @(negedge clk);
        chk("final_ready", 32'(ready), 32'd1);
        chk("final_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
